// File: rtl/shift_unit_arbiter_if.sv
// Handshake bundle between N_REQ shift requesters and the shared shift unit.
//   req_valid/req_data/req_shift : flat per-requester request fields
//                                  (slice i = requester i)
//   req_ready                    : one-hot (or zero) accept, driven by arbiter
//   res_valid/res_data/res_id    : registered result and winning requester
//   res_ready                    : consumer accepts the result
// slave modport = arbiter side, master modport = requester/consumer side.
interface shift_unit_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]      req_valid;
  logic [32*N_REQ-1:0]   req_data;
  logic [5*N_REQ-1:0]    req_shift;
  logic [N_REQ-1:0]      req_ready;
  logic                  res_valid;
  logic [31:0]           res_data;
  logic [ID_W-1:0]       res_id;
  logic                  res_ready;

  modport slave (
    input  req_valid, req_data, req_shift, res_ready,
    output req_ready, res_valid, res_data, res_id
  );

  modport master (
    output req_valid, req_data, req_shift, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/shift_unit_arbiter.sv
// Shared 32-bit logical-right barrel shifter with round-robin arbitration.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : shift_unit_arbiter_if.slave (request/result handshakes)
// One result register, loaded whenever it is empty or being consumed, so
// back-to-back grants give one result per cycle. The round-robin pointer
// moves only on a grant, to one past the winner.

// Combinational logical right shift, zeros fill from the MSB.
module barrel_shift_right_logical (
  input  logic [31:0] i_op,
  input  logic [4:0]  i_shamt,
  output logic [31:0] o_res
);
  logic [5:0][31:0] w_stage;

  assign w_stage[0] = i_op;
  for (genvar g = 0; g < 5; g++) begin : g_stage
    assign w_stage[g+1] = i_shamt[g] ?
      {{(2**g){1'b0}}, w_stage[g][31:2**g]} : w_stage[g];
  end
  assign o_res = w_stage[5];
endmodule

// Per-requester operand gate: passes the operand only when granted, so the
// lanes can be OR-combined into the shifter input.
module shift_arb_lane (
  input  logic        i_gnt,
  input  logic [31:0] i_data,
  input  logic [4:0]  i_shift,
  output logic [31:0] o_data,
  output logic [4:0]  o_shift
);
  assign o_data  = i_data  & {32{i_gnt}};
  assign o_shift = i_shift & {5{i_gnt}};
endmodule

module shift_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_unit_arbiter_if.slave  bus
);
  localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(N_REQ);

  logic [ID_W-1:0]             r_rr_ptr;
  logic                        r_res_valid;
  logic [31:0]                 r_res_data;
  logic [ID_W-1:0]             r_res_id;

  logic                        w_accept;
  logic                        w_any;
  logic [2*N_REQ-1:0]          w_dbl;
  logic [ID_W-1:0]             w_first;
  logic [ID_W:0]               w_sum;
  logic [ID_W-1:0]             w_win;
  logic [ID_W:0]               w_inc;
  logic [ID_W-1:0]             w_ptr_nxt;
  logic [N_REQ-1:0]            w_grant;
  logic [N_REQ-1:0]            w_req_ready;
  logic                        w_xfer;
  logic [N_REQ-1:0][31:0]      w_lane_data;
  logic [N_REQ-1:0][4:0]       w_lane_shift;
  logic [31:0]                 w_op;
  logic [4:0]                  w_shamt;
  logic [31:0]                 w_shifted;

  // rst_n gates accept so req_ready is 0 throughout reset, even though the
  // empty result register would otherwise allow a grant.
  assign w_accept = rst_n & (~r_res_valid | bus.res_ready);
  assign w_any    = |bus.req_valid;

  // Rotate the valid vector so bit 0 is the requester at rr_ptr; the first
  // set bit of the rotated vector is the scan distance to the winner.
  assign w_dbl = {bus.req_valid, bus.req_valid} >> r_rr_ptr;

  always_comb begin
    w_first = '0;
    for (int k = N_REQ-1; k >= 0; k--)
      if (w_dbl[k]) w_first = ID_W'(k);
  end

  assign w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_first};
  assign w_win     = (w_sum >= NREQ_W) ? ID_W'(w_sum - NREQ_W) : ID_W'(w_sum);
  assign w_inc     = {1'b0, w_win} + (ID_W+1)'(1);
  assign w_ptr_nxt = (w_inc == NREQ_W) ? '0 : ID_W'(w_inc);

  assign w_grant     = w_any ? (N_REQ'(1) << w_win) : '0;
  assign w_req_ready = w_accept ? w_grant : '0;
  assign w_xfer      = |w_req_ready;

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    shift_arb_lane u_lane (
      .i_gnt   (w_grant[g]),
      .i_data  (bus.req_data[32*g +: 32]),
      .i_shift (bus.req_shift[5*g +: 5]),
      .o_data  (w_lane_data[g]),
      .o_shift (w_lane_shift[g])
    );
  end

  // Grant is one-hot, so OR of gated lanes is the winner's operand.
  always_comb begin
    w_op    = '0;
    w_shamt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_op    = w_op    | w_lane_data[i];
      w_shamt = w_shamt | w_lane_shift[i];
    end
  end

  barrel_shift_right_logical u_shift (
    .i_op    (w_op),
    .i_shamt (w_shamt),
    .o_res   (w_shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_xfer) begin
      r_res_valid <= 1'b1;
      r_res_data  <= w_shifted;
      r_res_id    <= w_win;
      r_rr_ptr    <= w_ptr_nxt;
    end else if (bus.res_ready) begin
      // consumed with nothing new: data/id keep their last values
      r_res_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_id    = r_res_id;
endmodule

// File: tb/tb_shift_unit_arbiter.sv
module tb_shift_unit_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_unit_arbiter_if #(.N_REQ(N), .ID_W(IW)) bus();

  shift_unit_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [N-1:0]  v = '0;
  logic [31:0]   d [N];
  logic [4:0]    s [N];
  logic          rr = 1'b1;

  always_comb begin
    bus.req_valid = v;
    bus.res_ready = rr;
    bus.req_data  = '0;
    bus.req_shift = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_data[32*i +: 32] = d[i];
      bus.req_shift[5*i +: 5]  = s[i];
    end
  end

  typedef struct { logic [31:0] data; int id; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int m_ptr = 0;
  bit m_rv = 1'b0;
  logic [N-1:0] granted = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: round-robin scan as plain modular arithmetic, shift as >>.
  always @(negedge clk) begin
    int win;
    bit acc;
    logic [N-1:0] er;
    logic [IW-1:0] wi;
    if (!rst_n) begin
      m_ptr = 0;
      m_rv = 1'b0;
      granted = '0;
    end else begin
      acc = !m_rv || rr;
      win = -1;
      for (int k = 0; k < N; k++) begin
        wi = IW'((m_ptr + k) % N);
        if (win < 0 && v[wi]) win = (m_ptr + k) % N;
      end
      er = (acc && win >= 0) ? (N'(1) << win) : '0;
      chk("req_ready", 32'(bus.req_ready), 32'(er));
      chk("res_valid", 32'(bus.res_valid), 32'(m_rv));
      if (er != '0) begin
        wi = IW'(win);
        sb.push_back('{d[wi] >> s[wi], win});
        m_ptr = (win + 1) % N;
        m_rv = 1'b1;
      end else if (rr) begin
        m_rv = 1'b0;
      end
      granted = er;
    end
  end

  // Monitor: each consumed result is compared with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.res_valid && rr) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=id%0d expected=no_result", bus.res_id);
      end else begin
        e = sb.pop_front();
        chk("res_data", bus.res_data, e.data);
        chk("res_id", 32'(bus.res_id), 32'(e.id));
      end
    end
  end

  // Advance one clock; granted requesters withdraw their request.
  task automatic cyc();
    @(posedge clk);
    #1;
    v = v & ~granted;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && v != '0; t++) cyc();
    chk("drain", 32'(v), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      d[i] = 32'h1000_0000 + 32'(i);
      s[i] = 5'd0;
    end
    v = '1;
    rr = 1'b1;
    rst_n = 1'b0;
    repeat (2) cyc();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", bus.res_data, 32'd0);
    chk("rst_res_id", 32'(bus.res_id), 32'd0);
    rst_n = 1'b1;

    // round robin, all continuously valid, shift 0
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("rr_valid", 32'(bus.res_valid), 32'd1);
      chk("rr_id", 32'(bus.res_id), 32'(k % 4));
      chk("rr_data", bus.res_data, 32'h1000_0000 + 32'(k % 4));
      v = '1;
    end
    drain();

    // single request, shift 31
    d[2] = 32'h8000_0000; s[2] = 5'd31; v[2] = 1'b1;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h4);
    cyc();
    chk("single_valid", 32'(bus.res_valid), 32'd1);
    chk("single_data", bus.res_data, 32'h0000_0001);
    chk("single_id", 32'(bus.res_id), 32'd2);

    // pointer holds across idle cycles
    d[1] = $urandom; s[1] = 5'($urandom_range(0, 31)); v[1] = 1'b1;
    cyc();
    repeat (5) cyc();
    d[0] = $urandom; s[0] = 5'($urandom_range(0, 31));
    d[3] = $urandom; s[3] = 5'($urandom_range(0, 31));
    v[0] = 1'b1; v[3] = 1'b1;
    cyc();
    chk("ptr_first", 32'(bus.res_id), 32'd3);
    cyc();
    chk("ptr_second", 32'(bus.res_id), 32'd0);
    cyc();

    // backpressure
    d[0] = 32'hFFFF_FFFF; s[0] = 5'd4; v[0] = 1'b1; rr = 1'b0;
    cyc();
    d[1] = 32'h1234_5678; s[1] = 5'd8; v[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_data", bus.res_data, 32'h0FFF_FFFF);
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
      cyc();
    end
    rr = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.req_ready), 32'h2);
    cyc();
    chk("bp_next_id", 32'(bus.res_id), 32'd1);
    chk("bp_next_data", bus.res_data, 32'h0012_3456);

    // randomized traffic with random backpressure
    for (int t = 0; t < 400; t++) begin
      cyc();
      rr = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          d[i] = $urandom;
          s[i] = 5'($urandom_range(0, 31));
          v[i] = 1'b1;
        end
      end
    end
    rr = 1'b1;
    drain();
    cyc();

    // async reset while a result is pending
    d[2] = 32'hDEAD_BEEF; s[2] = 5'd0; v[2] = 1'b1; rr = 1'b0;
    cyc();
    chk("arst_pending", 32'(bus.res_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid_drop", 32'(bus.res_valid), 32'd0);
    sb.delete();
    v = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
    rr = 1'b1;
    for (int i = 0; i < N; i++) begin
      d[i] = $urandom;
      s[i] = 5'($urandom_range(0, 31));
    end
    v = '1;
    cyc();
    chk("arst_first_id", 32'(bus.res_id), 32'd0);
    cyc();
    chk("arst_second_id", 32'(bus.res_id), 32'd1);
    drain();

    for (int t = 0; t < 20 && sb.size() != 0; t++) cyc();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
